// File: rtl/riscv_pkg.sv
// Shared RV64 front-end definitions: machine widths, the NOP encoding,
// fetch FSM / next-PC select enums, base opcodes for the immediate
// generator, and small PC helper functions.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // Byte distance between consecutive fetches (fixed 32-bit encodings).
  localparam logic [XLEN-1:0] INST_BYTES = 64'd4;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  // Next-PC source select.
  typedef enum logic [1:0] {
    PC_SEL_HOLD  = 2'd0,
    PC_SEL_INC   = 2'd1,
    PC_SEL_REDIR = 2'd2
  } pc_sel_e;

  // RV64I base opcodes (inst[6:0]) consumed by the immediate-generation stage.
  localparam logic [6:0] OPC_LOAD      = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC     = 7'b001_0111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b001_1011;
  localparam logic [6:0] OPC_STORE     = 7'b010_0011;
  localparam logic [6:0] OPC_OP        = 7'b011_0011;
  localparam logic [6:0] OPC_LUI       = 7'b011_0111;
  localparam logic [6:0] OPC_OP_32     = 7'b011_1011;
  localparam logic [6:0] OPC_BRANCH    = 7'b110_0011;
  localparam logic [6:0] OPC_JALR      = 7'b110_0111;
  localparam logic [6:0] OPC_JAL       = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b111_0011;

  // True when an address is not on a 4-byte instruction boundary.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // Force an address onto a 4-byte instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage : riscv_pkg

// File: rtl/inst_fetch_pc_next.sv
// pc_next: combinational next-PC selection for the fetch unit.
// Chooses between holding the PC, the sequential PC (+4, wrapping modulo
// 2^64) and the aligned redirect target.
module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  pc_sel_e         sel_i,
  output logic [XLEN-1:0] pc_next_o
);

  // Select the next PC; the XLEN-wide add wraps naturally at 2^64.
  always_comb begin
    pc_next_o = pc_i;
    case (sel_i)
      PC_SEL_HOLD:  pc_next_o = pc_i;
      PC_SEL_INC:   pc_next_o = pc_i + INST_BYTES;
      PC_SEL_REDIR: pc_next_o = align_pc(redirect_pc_i);
      default:      pc_next_o = pc_i;
    endcase
  end

endmodule : pc_next

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch unit.
//
// A one-cycle IDLE after reset, then FETCH issues imem_req at the current
// PC. A response (imem_ready) is registered into inst/inst_pc/inst_valid
// one cycle later and the PC advances by 4. A stalled valid instruction
// parks the unit in HOLD with the request dropped. redirect always wins
// and discards any same-cycle response.
//
// Optional build macro MISALIGN_CHK_EN: a redirect to a target that is not
// 4-byte aligned raises the sticky misalign flag and parks the unit in ERR
// (no requests) until reset. Without it, misalign is tied low and the
// redirect target is silently aligned down.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [ILEN-1:0]   imem_rdata,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              stall,
  output logic [ILEN-1:0]   inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_valid,
  output logic              misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;

  logic            req_s;
  logic            redir_take_s;
  logic            bad_target_s;
  logic            accept_s;
  logic            consume_s;
  pc_sel_e         pc_sel_s;

`ifdef MISALIGN_CHK_EN
  logic            misalign_q, misalign_d;
`endif

  // Request is issued from FETCH unless a stalled instruction is still
  // occupying the output register; this term depends on the live stall
  // input so a response can never overwrite an instruction being held.
  always_comb begin
    if (state_q == ST_FETCH) begin
      req_s = (!inst_valid_q) || (!stall);
    end else begin
      req_s = 1'b0;
    end
  end

  // Misaligned-target detection exists only in the checked build.
  always_comb begin
`ifdef MISALIGN_CHK_EN
    bad_target_s = pc_misaligned(redirect_pc);
`else
    bad_target_s = 1'b0;
`endif
  end

  // Per-cycle event decode: taken redirect, accepted response, consumption.
  always_comb begin
    redir_take_s = redirect && (state_q != ST_ERR);
    accept_s     = req_s && imem_ready && (!redirect);
    consume_s    = inst_valid_q && (!stall);
  end

  // Choose the next-PC source: redirect first, then sequential advance.
  always_comb begin
    if (redir_take_s && !bad_target_s) begin
      pc_sel_s = PC_SEL_REDIR;
    end else if (accept_s) begin
      pc_sel_s = PC_SEL_INC;
    end else begin
      pc_sel_s = PC_SEL_HOLD;
    end
  end

  pc_next u_pc_next (
    .pc_i          (pc_q),
    .redirect_pc_i (redirect_pc),
    .sel_i         (pc_sel_s),
    .pc_next_o     (pc_d)
  );

  // Next FSM state; a taken redirect overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (redir_take_s) begin
      state_d = bad_target_s ? ST_ERR : ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: state_d = (inst_valid_q && stall) ? ST_HOLD : ST_FETCH;
        ST_HOLD:  state_d = stall ? ST_HOLD : ST_FETCH;
        ST_ERR:   state_d = ST_ERR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Next output-register contents: flush on redirect, load on response,
  // drop on consumption, otherwise hold.
  always_comb begin
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    if (redir_take_s) begin
      inst_valid_d = 1'b0;
    end else if (accept_s) begin
      inst_d       = imem_rdata;
      inst_pc_d    = pc_q;
      inst_valid_d = 1'b1;
    end else if (consume_s) begin
      inst_valid_d = 1'b0;
    end else begin
      inst_valid_d = inst_valid_q;
    end
  end

`ifdef MISALIGN_CHK_EN
  // Sticky misaligned-redirect flag; only reset clears it.
  always_comb begin
    misalign_d = misalign_q || (redir_take_s && bad_target_s);
  end
`endif

  // Fetch FSM and all architectural state, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      inst_pc_q    <= {XLEN{1'b0}};
      inst_valid_q <= 1'b0;
`ifdef MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
`ifdef MISALIGN_CHK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign imem_req   = req_s;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
`ifdef MISALIGN_CHK_EN
  assign misalign   = misalign_q;
`else
  assign misalign   = 1'b0;
`endif

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. A scoreboard queue holds the
// (pc, word) pair expected for each fetch issued; it is popped when the
// DUT presents the instruction. A second instance uses the top-of-memory
// RESET_PC to exercise PC wrap-around.
module tb_inst_fetch;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        stall;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        misalign;

  logic        w_req;
  logic [63:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_inst;
  logic [63:0] w_inst_pc;
  logic        w_valid;
  logic        w_misalign;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  inst_fetch #(.RESET_PC(64'h0000_0000_0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .misalign(misalign)
  );

  inst_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(w_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_valid(w_valid), .misalign(w_misalign)
  );

  // Memory image: one recognisable word at 0x8, address-derived elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8) return 32'h00A0_0093;
    return {a[31:2], 2'b11} ^ 32'h1357_0000;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);
  always_comb w_rdata    = mem_word(w_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("inst_pc", inst_pc, e.pc);
      check_eq("inst", 64'(inst), 64'(e.word));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},      64'(imem_req),   64'd0);
    check_eq({tag, "_addr"},     imem_addr,       64'h0);
    check_eq({tag, "_inst"},     64'(inst),       64'h0000_0013);
    check_eq({tag, "_inst_pc"},  inst_pc,         64'h0);
    check_eq({tag, "_valid"},    64'(inst_valid), 64'd0);
    check_eq({tag, "_misalign"}, 64'(misalign),   64'd0);
    check_eq({tag, "_w_addr"},   w_addr,          64'hFFFF_FFFF_FFFF_FFFC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    stall       = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // Release reset: one IDLE cycle without a request, then FETCH.
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    #1;
    check_eq("idle_req", 64'(imem_req), 64'd0);
    tick();
    check_eq("fetch1_valid", 64'(inst_valid), 64'd0);
    check_eq("fetch1_req",   64'(imem_req),   64'd1);
    check_eq("w_addr0",      w_addr,          64'hFFFF_FFFF_FFFF_FFFC);

    // Streaming fetch: addresses 0, 4, 8 with one-cycle response latency.
    for (int i = 0; i < 3; i++) begin
      check_eq("stream_addr", imem_addr, 64'(4 * i));
      check_eq("stream_req",  64'(imem_req), 64'd1);
      if (i == 1) begin
        check_eq("w_addr_wrap", w_addr,          64'h0);
        check_eq("w_inst_pc",   w_inst_pc,       64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("w_inst",      64'(w_inst),     64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
        check_eq("w_valid",     64'(w_valid),    64'd1);
        check_eq("w_req",       64'(w_req),      64'd1);
        check_eq("w_misalign",  64'(w_misalign), 64'd0);
      end
      sb_q.push_back('{pc: 64'(4 * i), word: mem_word(64'(4 * i))});
      tick();
      check_eq("stream_valid", 64'(inst_valid), 64'd1);
      sb_pop_check();
    end

    // Stall three cycles on the valid addi word.
    stall = 1'b1;
    #1;
    check_eq("stall_req", 64'(imem_req), 64'd0);
    repeat (3) begin
      tick();
      check_eq("hold_inst",    64'(inst),       64'h00A0_0093);
      check_eq("hold_inst_pc", inst_pc,         64'h8);
      check_eq("hold_valid",   64'(inst_valid), 64'd1);
      check_eq("hold_req",     64'(imem_req),   64'd0);
      check_eq("hold_addr",    imem_addr,       64'hC);
    end
    stall = 1'b0;
    #1;
    check_eq("hold_exit_req", 64'(imem_req), 64'd0);
    tick();
    check_eq("resume_valid", 64'(inst_valid), 64'd0);
    check_eq("resume_addr",  imem_addr,       64'hC);
    check_eq("resume_req",   64'(imem_req),   64'd1);
    sb_q.push_back('{pc: 64'hC, word: mem_word(64'hC)});
    tick();
    check_eq("resume_fetch_valid", 64'(inst_valid), 64'd1);
    sb_pop_check();

    // Redirect coincident with a response: response dropped.
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    check_eq("redir_valid", 64'(inst_valid), 64'd0);
    check_eq("redir_addr",  imem_addr,       64'h100);
    sb_q.push_back('{pc: 64'h100, word: mem_word(64'h100)});
    tick();
    check_eq("redir_fetch_valid", 64'(inst_valid), 64'd1);
    sb_pop_check();

    // Misaligned redirect target.
    redirect    = 1'b1;
    redirect_pc = 64'h102;
    tick();
    redirect = 1'b0;
`ifdef MISALIGN_CHK_EN
    check_eq("mis_flag",  64'(misalign),   64'd1);
    check_eq("mis_valid", 64'(inst_valid), 64'd0);
    repeat (3) begin
      tick();
      check_eq("err_req",  64'(imem_req), 64'd0);
      check_eq("err_flag", 64'(misalign), 64'd1);
    end
`else
    check_eq("mis_flag",  64'(misalign),   64'd0);
    check_eq("mis_addr",  imem_addr,       64'h100);
    check_eq("mis_valid", 64'(inst_valid), 64'd0);
    sb_q.push_back('{pc: 64'h100, word: mem_word(64'h100)});
    tick();
    check_eq("mis_fetch_valid", 64'(inst_valid), 64'd1);
    sb_pop_check();
    check_eq("mis_flag_after", 64'(misalign), 64'd0);
`endif

    // Fresh start, then asynchronous reset while in HOLD.
    do_reset();
    check_eq("rerun_addr", imem_addr, 64'h0);
    sb_q.push_back('{pc: 64'h0, word: mem_word(64'h0)});
    tick();
    check_eq("rerun_valid", 64'(inst_valid), 64'd1);
    sb_pop_check();
    stall = 1'b1;
    tick();
    check_eq("pre_rst_hold_req",   64'(imem_req),   64'd0);
    check_eq("pre_rst_hold_valid", 64'(inst_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_idle_req", 64'(imem_req), 64'd0);
    tick();
    check_eq("refetch_addr", imem_addr,     64'h0);
    check_eq("refetch_req",  64'(imem_req), 64'd1);
    sb_q.push_back('{pc: 64'h0, word: mem_word(64'h0)});
    tick();
    check_eq("refetch_valid", 64'(inst_valid), 64'd1);
    sb_pop_check();

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_inst_fetch
